// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for the digit-serial adder/subtractor.
// slave is the adder side, master is the producer/consumer side.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport slave (
    input  in_valid, a, b, sub, abort,
    input  out_ready,
    output in_ready, out_valid, out,
    output cout, ovf, busy
  );

  modport master (
    output in_valid, a, b, sub, abort,
    output out_ready,
    input  in_ready, out_valid, out,
    input  cout, ovf, busy
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor, DIGIT bits per cycle, LSB first.
// Subtraction is A + ~B + 1 with the +1 entering as the initial carry.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic            clk,
  input logic            rst_n,
  serial_addsub_if.slave io
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] shin;
  logic                   ovf_w;

  assign dsum = {1'b0, a_q[DIGIT-1:0]}
              + {1'b0, b_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};

  // New digit enters at the top; the register fills LSB-first.
  assign shin = {dsum[DIGIT-1:0], out_q};

  assign ovf_w = (a_q[DIGIT-1] == b_q[DIGIT-1])
              && (dsum[DIGIT-1] != a_q[DIGIT-1]);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d     = io.a;
          b_d     = io.sub ? ~io.b : io.b;
          carry_d = io.sub;
          count_d = '0;
          out_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        if (io.abort) begin
          state_d = IDLE;
        end else begin
          out_d   = shin[WIDTH+DIGIT-1:DIGIT];
          a_d     = a_q >> DIGIT;
          b_d     = b_q >> DIGIT;
          carry_d = dsum[DIGIT];
          if (count_q == LAST) begin
            cout_d  = dsum[DIGIT];
            ovf_d   = ovf_w;
            state_d = DONE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.busy      = (state_q == ADD);
  assign io.out       = out_q;
  assign io.cout      = cout_q;
  assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub in three digit/width configurations.
// Results are hand-computed two's-complement sums and differences.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8))  b8 ();
  serial_addsub_if #(.WIDTH(8))  b84 ();
  serial_addsub_if #(.WIDTH(16)) b16 ();

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n), .io(b8)
  );
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u84 (
    .clk(clk), .rst_n(rst_n), .io(b84)
  );
  serial_addsub #(.WIDTH(16), .DIGIT(2)) u16 (
    .clk(clk), .rst_n(rst_n), .io(b16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one op on the DIGIT=1 unit and wait for out_valid.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic s, output int lat,
                      output int bcyc);
    b8.a = a;
    b8.b = b;
    b8.sub = s;
    b8.in_valid = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    lat = 0;
    bcyc = 0;
    while (!b8.out_valid && lat < 20) begin
      if (b8.busy) bcyc++;
      tick();
      lat++;
    end
  endtask

  task automatic accept8();
    b8.out_ready = 1'b1;
    tick();
    b8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    nvec++;
    if (b8.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_in_ready got %b exp 1", b8.in_ready);
    end
    nvec++;
    if (b8.out_valid !== 1'b0 || b8.busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_flags got v=%b b=%b exp 0 0",
               b8.out_valid, b8.busy);
    end
    nvec++;
    if ({b8.out, b8.cout, b8.ovf} !== 10'h0) begin
      nerr++;
      $display("FAIL reset_result got %h/%b/%b exp 00/0/0",
               b8.out, b8.cout, b8.ovf);
    end
  endtask

  task automatic test_add_basic();
    int lat, bc;
    run8(8'h35, 8'h4A, 1'b0, lat, bc);
    nvec++;
    if (lat !== 8) begin
      nerr++;
      $display("FAIL add_latency got %0d exp 8", lat);
    end
    nvec++;
    if (bc !== 8) begin
      nerr++;
      $display("FAIL add_busy got %0d exp 8", bc);
    end
    nvec++;
    if ({b8.out, b8.cout, b8.ovf} !== {8'h7F, 2'b00}) begin
      nerr++;
      $display("FAIL add_35_4a got %h/%b/%b exp 7f/0/0",
               b8.out, b8.cout, b8.ovf);
    end
    accept8();
  endtask

  task automatic test_ovf();
    logic [7:0] ta [3] = '{8'h7F, 8'h10, 8'h80};
    logic [7:0] tb [3] = '{8'h01, 8'h20, 8'h01};
    logic       ts [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] eo [3] = '{8'h80, 8'hF0, 8'h7F};
    logic       ec [3] = '{1'b0, 1'b0, 1'b1};
    logic       ev [3] = '{1'b1, 1'b0, 1'b1};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run8(ta[i], tb[i], ts[i], lat, bc);
      nvec++;
      if (b8.out_valid !== 1'b1 ||
          {b8.out, b8.cout, b8.ovf} !==
          {eo[i], ec[i], ev[i]}) begin
        nerr++;
        $display("FAIL ovf_vec%0d got %h/%b/%b exp %h/%b/%b",
                 i, b8.out, b8.cout, b8.ovf,
                 eo[i], ec[i], ev[i]);
      end
      accept8();
    end
  endtask

  task automatic test_digit4();
    int lat = 0;
    b84.a = 8'hFF;
    b84.b = 8'h01;
    b84.sub = 1'b0;
    b84.in_valid = 1'b1;
    tick();
    b84.in_valid = 1'b0;
    while (!b84.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    nvec++;
    if (lat !== 2) begin
      nerr++;
      $display("FAIL d4_latency got %0d exp 2", lat);
    end
    nvec++;
    if ({b84.out, b84.cout, b84.ovf} !== {8'h00, 2'b10}) begin
      nerr++;
      $display("FAIL d4_ff_01 got %h/%b/%b exp 00/1/0",
               b84.out, b84.cout, b84.ovf);
    end
    b84.out_ready = 1'b1;
    tick();
    b84.out_ready = 1'b0;
  endtask

  task automatic test_w16_d2();
    int lat = 0;
    b16.a = 16'hFFFF;
    b16.b = 16'h0001;
    b16.sub = 1'b0;
    b16.in_valid = 1'b1;
    tick();
    b16.in_valid = 1'b0;
    while (!b16.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    nvec++;
    if (lat !== 8) begin
      nerr++;
      $display("FAIL w16_latency got %0d exp 8", lat);
    end
    nvec++;
    if ({b16.out, b16.cout, b16.ovf} !== {16'h0000, 2'b10}) begin
      nerr++;
      $display("FAIL w16_ffff_1 got %h/%b/%b exp 0000/1/0",
               b16.out, b16.cout, b16.ovf);
    end
    b16.out_ready = 1'b1;
    tick();
    b16.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat, bc;
    run8(8'h7F, 8'h01, 1'b0, lat, bc);
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++;
      if (b8.out_valid !== 1'b1 || b8.in_ready !== 1'b0 ||
          {b8.out, b8.cout, b8.ovf} !== {8'h80, 2'b01}) begin
        nerr++;
        $display("FAIL bp_hold%0d got v=%b r=%b %h/%b/%b exp 1 0 80/0/1",
                 i, b8.out_valid, b8.in_ready,
                 b8.out, b8.cout, b8.ovf);
      end
    end
    accept8();
    nvec++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL bp_release got r=%b v=%b exp 1 0",
               b8.in_ready, b8.out_valid);
    end
    nvec++;
    if (b8.out !== 8'h80) begin
      nerr++;
      $display("FAIL bp_keep got %h exp 80", b8.out);
    end
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    b8.a = 8'h01;
    b8.b = 8'h02;
    b8.sub = 1'b0;
    b8.in_valid = 1'b1;
    tick();
    b8.a = 8'h10;
    b8.b = 8'h20;
    while (!b8.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    nvec++;
    if (b8.out_valid !== 1'b1 || b8.out !== 8'h03) begin
      nerr++;
      $display("FAIL b2b_first got v=%b %h exp 1 03",
               b8.out_valid, b8.out);
    end
    b8.out_ready = 1'b1;
    tick();
    nvec++;
    if (b8.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_idle got %b exp 1", b8.in_ready);
    end
    tick();
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b0;
    nvec++;
    if (b8.busy !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_restart got %b exp 1", b8.busy);
    end
    lat = 0;
    while (!b8.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    nvec++;
    if (b8.out_valid !== 1'b1 || b8.out !== 8'h30) begin
      nerr++;
      $display("FAIL b2b_second got v=%b %h exp 1 30",
               b8.out_valid, b8.out);
    end
    accept8();
  endtask

  task automatic test_abort();
    int lat, bc;
    int seen = 0;
    b8.a = 8'h55;
    b8.b = 8'h11;
    b8.sub = 1'b0;
    b8.in_valid = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    tick();
    tick();
    tick();
    b8.abort = 1'b1;
    tick();
    b8.abort = 1'b0;
    nvec++;
    if (b8.in_ready !== 1'b1 || b8.busy !== 1'b0) begin
      nerr++;
      $display("FAIL abort_idle got r=%b b=%b exp 1 0",
               b8.in_ready, b8.busy);
    end
    for (int i = 0; i < 12; i++) begin
      if (b8.out_valid) seen++;
      tick();
    end
    nvec++;
    if (seen !== 0) begin
      nerr++;
      $display("FAIL abort_no_valid got %0d exp 0", seen);
    end
    run8(8'h01, 8'h02, 1'b0, lat, bc);
    nvec++;
    if (b8.out_valid !== 1'b1 || b8.out !== 8'h03) begin
      nerr++;
      $display("FAIL abort_next got v=%b %h exp 1 03",
               b8.out_valid, b8.out);
    end
    accept8();
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    run8(8'h80, 8'h01, 1'b1, lat, bc);
    accept8();
    b8.a = 8'h35;
    b8.b = 8'h4A;
    b8.sub = 1'b0;
    b8.in_valid = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (b8.in_ready !== 1'b1 || b8.busy !== 1'b0) begin
      nerr++;
      $display("FAIL rst_mid_state got r=%b b=%b exp 1 0",
               b8.in_ready, b8.busy);
    end
    nvec++;
    if ({b8.out, b8.cout, b8.ovf} !== 10'h0) begin
      nerr++;
      $display("FAIL rst_mid_result got %h/%b/%b exp 00/0/0",
               b8.out, b8.cout, b8.ovf);
    end
    tick();
    rst_n = 1'b1;
    tick();
    nvec++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_release got r=%b v=%b exp 1 0",
               b8.in_ready, b8.out_valid);
    end
  endtask

  initial begin
    b8.in_valid = 0; b8.a = 0; b8.b = 0; b8.sub = 0;
    b8.abort = 0; b8.out_ready = 0;
    b84.in_valid = 0; b84.a = 0; b84.b = 0; b84.sub = 0;
    b84.abort = 0; b84.out_ready = 0;
    b16.in_valid = 0; b16.a = 0; b16.b = 0; b16.sub = 0;
    b16.abort = 0; b16.out_ready = 0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_add_basic();
    test_ovf();
    test_digit4();
    test_w16_d2();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised digit-serial adder/subtractor, the next generation of the team's bit-serial add block. It accepts two WIDTH-bit operands through a valid/ready handshake and processes DIGIT bits per cycle, LSB first. It returns sum or difference with carry-out and signed overflow through a second valid/ready handshake. It sits between operand-producing control logic and a result consumer where area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥ 2.
DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. The number of ADD cycles is N = WIDTH/DIGIT.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands and mode are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A (unsigned or two's complement).
b  input  WIDTH  operand B.
sub  input  1  0: A+B; 1: A−B; sampled with operands.
abort  input  1  cancel the operation in progress.
out_valid  output  1  result fields are valid.
out_ready  input  1  consumer accepts the result.
out  output  WIDTH  sum or difference.
cout  output  1  final carry-out; for subtraction, 1 means no borrow.
ovf  output  1  signed two's-complement overflow.
busy  output  1  high while in ADD.

Behaviour:
- Reset (rst_n low, asynchronous): state goes to IDLE; a_reg, b_reg, out, count, carry, cout and ovf all go to 0. Outputs: in_ready=1, out_valid=0, busy=0.
- States are IDLE, ADD and DONE; the state encoding is 2 bits and the fourth code is illegal.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - busy = (state==ADD).
- IDLE:
  - When in_valid is high at an edge, the block loads a_reg←a, b_reg←(sub ? ~b : b), carry←sub, count←0, and clears out to 0.
  - It then moves to ADD.
  - in_valid low: the block stays in IDLE and all registers hold.
- ADD, on each edge:
  - A DIGIT-wide add is performed on a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry.
  - out ← {digit_sum, out[WIDTH-1:DIGIT]}.
  - a_reg and b_reg shift right by DIGIT.
  - carry ← the digit carry-out, and count increments.
- Last ADD edge (count==N−1):
  - The block also latches cout ← the digit carry-out.
  - It latches ovf ← (msb_a == msb_b') && (msb_sum != msb_a), using the top bits of the final digit.
  - It then moves to DONE.
  - count is log2(N)+1 bits wide (minimum 1) and never wraps inside an operation.
- Latency: a handshake at edge E0 gives out_valid high after edge E0+N. WIDTH=8, DIGIT=1 gives N=8; WIDTH=8, DIGIT=4 gives N=2.
- DONE:
  - out, cout and ovf hold stable while out_valid=1 and out_ready=0.
  - When out_ready is high at an edge, the block moves to IDLE. Result registers hold their values until the next load.
  - in_ready is 0 in DONE, so a new operation cannot start in the same cycle as result acceptance.
- abort:
  - abort high in ADD sends the block to IDLE on the next edge and no out_valid is produced.
  - abort is ignored in IDLE and in DONE.
  - abort takes priority over last-digit completion.
- Illegal state code: the block returns to IDLE on the next edge.
- Inputs a, b and sub are don't-care outside the accepting IDLE edge; changing them during ADD has no effect.
- Reset asserted mid-ADD or in DONE: the block returns to IDLE immediately and the pending result is lost.

Test Plan:
1. WIDTH=8, DIGIT=1, sub=0, a=8'h35, b=8'h4A → out_valid rises exactly 8 cycles after the handshake; out=8'h7F, cout=0, ovf=0; busy is high for exactly 8 cycles.
2. sub=0, a=8'h7F, b=8'h01 → out=8'h80, cout=0, ovf=1. sub=1, a=8'h10, b=8'h20 → out=8'hF0, cout=0, ovf=0. sub=1, a=8'h80, b=8'h01 → out=8'h7F, cout=1, ovf=1.
3. DIGIT=4, a=8'hFF, b=8'h01, sub=0 → out_valid rises after 2 cycles; out=8'h00, cout=1, ovf=0. Repeat with WIDTH=16, DIGIT=2: a=16'hFFFF, b=16'h0001 → N=8, out=16'h0000, cout=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid rises → out, cout and ovf stay stable and in_ready stays 0; raising out_ready gives IDLE next cycle with in_ready=1. Back-to-back operations with in_valid held high → a new handshake occurs 1 cycle after acceptance, with no result corruption.
5. Abort: assert abort in the 4th ADD cycle → the block is in IDLE next edge, out_valid is never asserted, and the next operation (a=8'h01, b=8'h02) gives out=8'h03.
6. Reset: drive rst_n low asynchronously mid-ADD → state becomes IDLE and out, cout, ovf=0 before the next clock edge; in_ready=1 after release.
